// File: rtl/snake_engine_if.sv
// snake_engine_if: game-control and pixel-query bundle for snake_engine.
//   master : direction decoder / renderer side (drives start, update_tick,
//            direction, x_in, y_in; observes entity and status)
//   slave  : snake_engine side
// Ports carried:
//   start, update_tick, direction[1:0], x_in[9:0], y_in[9:0]  (to engine)
//   entity[1:0], game_over, game_won, tail_count[TW-1:0], busy (from engine)
// TW must equal clog2(MAX_TAILS+1) of the engine it connects to.

`ifndef LEFT_DIR
`define LEFT_DIR 2'd0
`endif
`ifndef TOP_DIR
`define TOP_DIR 2'd1
`endif
`ifndef RIGHT_DIR
`define RIGHT_DIR 2'd2
`endif
`ifndef DOWN_DIR
`define DOWN_DIR 2'd3
`endif
`ifndef ENT_NOTHING
`define ENT_NOTHING 2'd0
`endif
`ifndef ENT_APPLE
`define ENT_APPLE 2'd1
`endif
`ifndef ENT_SNAKE_HEAD
`define ENT_SNAKE_HEAD 2'd2
`endif
`ifndef ENT_SNAKE_TAIL
`define ENT_SNAKE_TAIL 2'd3
`endif

interface snake_engine_if #(
  parameter int TW = 5
) ();
  logic          start;
  logic          update_tick;
  logic [1:0]    direction;
  logic [9:0]    x_in;
  logic [9:0]    y_in;
  logic [1:0]    entity;
  logic          game_over;
  logic          game_won;
  logic [TW-1:0] tail_count;
  logic          busy;

  modport master (
    output start, update_tick, direction, x_in, y_in,
    input  entity, game_over, game_won, tail_count, busy
  );

  modport slave (
    input  start, update_tick, direction, x_in, y_in,
    output entity, game_over, game_won, tail_count, busy
  );
endinterface

// File: rtl/snake_engine.sv
// snake_engine: parametrised snake game core. Tail coordinates are kept in a
// circular buffer; self-collision and apple placement are sequential scans.
// Game steps advance on update_tick; pixel queries are answered every clock
// with one cycle of latency.
// Ports:
//   vga_clk  - sole clock
//   reset_n  - asynchronous active-low reset
//   bus      - snake_engine_if.slave (start, update_tick, direction, x_in,
//              y_in in; entity, game_over, game_won, tail_count, busy out)
// Optional feature: define SNAKE_TIME_LIMIT_EN to enable a time-based win
// after TIME_LIMIT accepted game steps.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | game live, waiting for update_tick; samples direction
// MOVE  | one cycle: turn, step head, push old head into tail buffer
// SCAN  | compare one body entry per cycle against the new head
// PLACE | find a free cell for the new apple
// OVER  | collision ended the game, waiting for start
// WON   | win (length or time), waiting for start

`ifndef LEFT_DIR
`define LEFT_DIR 2'd0
`endif
`ifndef TOP_DIR
`define TOP_DIR 2'd1
`endif
`ifndef RIGHT_DIR
`define RIGHT_DIR 2'd2
`endif
`ifndef DOWN_DIR
`define DOWN_DIR 2'd3
`endif
`ifndef ENT_NOTHING
`define ENT_NOTHING 2'd0
`endif
`ifndef ENT_APPLE
`define ENT_APPLE 2'd1
`endif
`ifndef ENT_SNAKE_HEAD
`define ENT_SNAKE_HEAD 2'd2
`endif
`ifndef ENT_SNAKE_TAIL
`define ENT_SNAKE_TAIL 2'd3
`endif

module snake_engine #(
  parameter int         GRID_W    = 40,
  parameter int         GRID_H    = 30,
  parameter int         CELL_W    = 16,
  parameter int         CELL_H    = 16,
  parameter int         MAX_TAILS = 16,
  parameter int         WRAP      = 0,
  parameter logic [9:0] LFSR_SEED = 10'h2A5
`ifdef SNAKE_TIME_LIMIT_EN
  , parameter int       TIME_LIMIT = 1000
`endif
) (
  input logic         vga_clk,
  input logic         reset_n,
  snake_engine_if.slave bus
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int TW = $clog2(MAX_TAILS + 1);
  localparam int PW = (MAX_TAILS > 1) ? $clog2(MAX_TAILS) : 1;

  localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_START  = XW'(GRID_W / 2);
  localparam logic [YW-1:0] Y_START  = YW'(GRID_H / 2);
  localparam logic [XW-1:0] APPLE_X0 = XW'(GRID_W / 2 + 4);
  localparam logic [TW-1:0] TAIL_FULL = TW'(MAX_TAILS);
  localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_TAILS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_MOVE, S_SCAN, S_PLACE, S_OVER, S_WON
  } state_t;

  state_t state, state_nxt;

  logic [XW-1:0] head_x, apple_x, cand_x, next_x;
  logic [YW-1:0] head_y, apple_y, cand_y, next_y;
  logic [1:0]    heading, pending_dir, eff_dir;
  logic [XW-1:0] tails_x [MAX_TAILS];
  logic [YW-1:0] tails_y [MAX_TAILS];
  logic [PW-1:0] wr_ptr, rd_idx;
  logic [TW-1:0] tail_count, scan_k;
  logic [9:0]    lfsr;
  logic          ate, game_over, game_won;
  logic          restart, off_grid, scan_last, body_hit, cand_hit, win_now, time_up;
  logic [9:0]    px_cx, px_cy;
  logic          body_px;
  logic [1:0]    ent_nxt, entity_q;

  function automatic logic [1:0] reverse_of(input logic [1:0] d);
    logic [1:0] r;
    r = `LEFT_DIR;
    case (d)
      `LEFT_DIR:  r = `RIGHT_DIR;
      `RIGHT_DIR: r = `LEFT_DIR;
      `TOP_DIR:   r = `DOWN_DIR;
      default:    r = `TOP_DIR;
    endcase
    return r;
  endfunction

  assign restart = (state == S_IDLE || state == S_OVER || state == S_WON) && bus.start;

`ifdef SNAKE_TIME_LIMIT_EN
  // Remaining steps until the time win; terminal count at zero.
  localparam int CW = $clog2(TIME_LIMIT + 1);
  logic [CW-1:0] time_left;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)
      time_left <= CW'(TIME_LIMIT);
    else if (restart)
      time_left <= CW'(TIME_LIMIT);
    else if (state == S_RUN && bus.update_tick && time_left != '0)
      time_left <= time_left - 1'b1;
  end

  assign time_up = (time_left == '0);
`else
  assign time_up = 1'b0;
`endif

  // Next head position and edge detection.
  always_comb begin
    eff_dir  = (pending_dir == reverse_of(heading)) ? heading : pending_dir;
    next_x   = head_x;
    next_y   = head_y;
    off_grid = 1'b0;
    case (eff_dir)
      `LEFT_DIR: begin
        if (head_x == '0) begin off_grid = 1'b1; next_x = X_MAX; end
        else next_x = head_x - 1'b1;
      end
      `RIGHT_DIR: begin
        if (head_x == X_MAX) begin off_grid = 1'b1; next_x = '0; end
        else next_x = head_x + 1'b1;
      end
      `TOP_DIR: begin
        if (head_y == '0) begin off_grid = 1'b1; next_y = Y_MAX; end
        else next_y = head_y - 1'b1;
      end
      default: begin
        if (head_y == Y_MAX) begin off_grid = 1'b1; next_y = '0; end
        else next_y = head_y + 1'b1;
      end
    endcase
    if (WRAP != 0) off_grid = 1'b0;
  end

  // Body entry of age scan_k lives at (wr_ptr-1-scan_k) mod MAX_TAILS.
  always_comb begin
    int sum;
    sum = int'(wr_ptr) + MAX_TAILS - 1 - int'(scan_k);
    if (sum >= MAX_TAILS) sum = sum - MAX_TAILS;
    rd_idx = PW'(sum);
  end

  assign scan_last = (tail_count == '0) || (scan_k == tail_count - 1'b1);
  assign body_hit  = (tail_count != '0) &&
                     (tails_x[rd_idx] == head_x) && (tails_y[rd_idx] == head_y);
  // The head is re-checked every PLACE cycle alongside the body entry.
  assign cand_hit  = ((cand_x == head_x) && (cand_y == head_y)) ||
                     ((tail_count != '0) &&
                      (tails_x[rd_idx] == cand_x) && (tails_y[rd_idx] == cand_y));
  assign win_now   = time_up || (ate && tail_count == TAIL_FULL);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_OVER, S_WON: if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (bus.update_tick) state_nxt = S_MOVE;
      S_MOVE:  state_nxt = off_grid ? S_OVER : S_SCAN;
      S_SCAN: begin
        if (body_hit)       state_nxt = S_OVER;
        else if (scan_last) begin
          if (win_now)      state_nxt = S_WON;
          else if (ate)     state_nxt = S_PLACE;
          else              state_nxt = S_RUN;
        end
      end
      S_PLACE: if (!cand_hit && scan_last) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (state == S_MOVE && !off_grid) begin
      tails_x[wr_ptr] <= head_x;
      tails_y[wr_ptr] <= head_y;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      head_x      <= X_START;
      head_y      <= Y_START;
      heading     <= `RIGHT_DIR;
      pending_dir <= `RIGHT_DIR;
      apple_x     <= APPLE_X0;
      apple_y     <= Y_START;
      cand_x      <= '0;
      cand_y      <= '0;
      tail_count  <= '0;
      wr_ptr      <= '0;
      scan_k      <= '0;
      ate         <= 1'b0;
      lfsr        <= LFSR_SEED;
      game_over   <= 1'b0;
      game_won    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_OVER, S_WON: begin
          if (bus.start) begin
            head_x      <= X_START;
            head_y      <= Y_START;
            heading     <= `RIGHT_DIR;
            pending_dir <= `RIGHT_DIR;
            apple_x     <= APPLE_X0;
            apple_y     <= Y_START;
            tail_count  <= '0;
            wr_ptr      <= '0;
            scan_k      <= '0;
            ate         <= 1'b0;
            game_over   <= 1'b0;
            game_won    <= 1'b0;
          end
        end
        S_RUN: pending_dir <= bus.direction;
        S_MOVE: begin
          heading <= eff_dir;
          if (off_grid) begin
            game_over <= 1'b1;
          end else begin
            head_x <= next_x;
            head_y <= next_y;
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            scan_k <= '0;
            ate    <= (next_x == apple_x) && (next_y == apple_y);
            if ((next_x == apple_x) && (next_y == apple_y) && tail_count != TAIL_FULL)
              tail_count <= tail_count + 1'b1;
          end
        end
        S_SCAN: begin
          if (body_hit) begin
            game_over <= 1'b1;
          end else if (scan_last) begin
            if (win_now) begin
              game_won <= 1'b1;
            end else if (ate) begin
              cand_x <= XW'(int'(lfsr[4:0]) % GRID_W);
              cand_y <= YW'(int'(lfsr[9:5]) % GRID_H);
              lfsr   <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
              scan_k <= '0;
            end
          end else begin
            scan_k <= scan_k + 1'b1;
          end
        end
        S_PLACE: begin
          if (cand_hit) begin
            // Linear advance visits every cell, so a free one is always found.
            scan_k <= '0;
            if (cand_x == X_MAX) begin
              cand_x <= '0;
              cand_y <= (cand_y == Y_MAX) ? '0 : cand_y + 1'b1;
            end else begin
              cand_x <= cand_x + 1'b1;
            end
          end else if (scan_last) begin
            apple_x <= cand_x;
            apple_y <= cand_y;
          end else begin
            scan_k <= scan_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel query: body compare is parallel over entries younger than tail_count.
  always_comb begin
    px_cx   = bus.x_in / 10'(CELL_W);
    px_cy   = bus.y_in / 10'(CELL_H);
    body_px = 1'b0;
    for (int i = 0; i < MAX_TAILS; i++) begin
      int age;
      age = int'(wr_ptr) - 1 - i;
      if (age < 0) age = age + MAX_TAILS;
      if (age < int'(tail_count) &&
          10'(tails_x[i]) == px_cx && 10'(tails_y[i]) == px_cy)
        body_px = 1'b1;
    end
    ent_nxt = `ENT_NOTHING;
    if (px_cx < 10'(GRID_W) && px_cy < 10'(GRID_H)) begin
      if (px_cx == 10'(head_x) && px_cy == 10'(head_y))
        ent_nxt = `ENT_SNAKE_HEAD;
      else if (px_cx == 10'(apple_x) && px_cy == 10'(apple_y))
        ent_nxt = `ENT_APPLE;
      else if (body_px)
        ent_nxt = `ENT_SNAKE_TAIL;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) entity_q <= `ENT_NOTHING;
    else          entity_q <= ent_nxt;
  end

  assign bus.entity     = entity_q;
  assign bus.game_over  = game_over;
  assign bus.game_won   = game_won;
  assign bus.tail_count = tail_count;
  assign bus.busy       = (state == S_MOVE) || (state == S_SCAN) || (state == S_PLACE);

endmodule

// File: tb/tb_snake_engine.sv
// Four engines share one stimulus stream:
//   0: default (WRAP=0, MAX_TAILS=16)   1: WRAP=1
//   2: MAX_TAILS=1                       3: default, TIME_LIMIT=10 when enabled
module tb_snake_engine;

  localparam int CELL  = 16;
  localparam int BOUND = 2 * (16 + 2) * 40 * 30;
  localparam logic [1:0] D_LEFT = 2'd0, D_TOP = 2'd1, D_RIGHT = 2'd2;
  localparam int E_NONE = 0, E_APPLE = 1, E_HEAD = 2, E_TAIL = 3;
`ifdef SNAKE_TIME_LIMIT_EN
  localparam int TL_ON = 1;
`else
  localparam int TL_ON = 0;
`endif

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic       start, update_tick;
  logic [1:0] direction;
  logic [9:0] x_in, y_in;

  int vectors = 0;
  int miscompares = 0;
  int ticks = 0;
  logic [1:0] exp_q[$];

  logic [1:0] ent [4];
  logic       over [4];
  logic       won [4];
  logic       busy [4];
  logic [7:0] tc [4];

  always #5 vga_clk = ~vga_clk;

  snake_engine_if #(.TW(5)) if_a ();
  snake_engine_if #(.TW(5)) if_b ();
  snake_engine_if #(.TW(1)) if_c ();
  snake_engine_if #(.TW(5)) if_d ();

  assign if_a.start = start; assign if_a.update_tick = update_tick; assign if_a.direction = direction;
  assign if_a.x_in = x_in; assign if_a.y_in = y_in;
  assign if_b.start = start; assign if_b.update_tick = update_tick; assign if_b.direction = direction;
  assign if_b.x_in = x_in; assign if_b.y_in = y_in;
  assign if_c.start = start; assign if_c.update_tick = update_tick; assign if_c.direction = direction;
  assign if_c.x_in = x_in; assign if_c.y_in = y_in;
  assign if_d.start = start; assign if_d.update_tick = update_tick; assign if_d.direction = direction;
  assign if_d.x_in = x_in; assign if_d.y_in = y_in;

  assign ent[0] = if_a.entity; assign over[0] = if_a.game_over; assign won[0] = if_a.game_won;
  assign busy[0] = if_a.busy;  assign tc[0] = 8'(if_a.tail_count);
  assign ent[1] = if_b.entity; assign over[1] = if_b.game_over; assign won[1] = if_b.game_won;
  assign busy[1] = if_b.busy;  assign tc[1] = 8'(if_b.tail_count);
  assign ent[2] = if_c.entity; assign over[2] = if_c.game_over; assign won[2] = if_c.game_won;
  assign busy[2] = if_c.busy;  assign tc[2] = 8'(if_c.tail_count);
  assign ent[3] = if_d.entity; assign over[3] = if_d.game_over; assign won[3] = if_d.game_won;
  assign busy[3] = if_d.busy;  assign tc[3] = 8'(if_d.tail_count);

  snake_engine u_a (.vga_clk(vga_clk), .reset_n(reset_n), .bus(if_a.slave));
  snake_engine #(.WRAP(1)) u_b (.vga_clk(vga_clk), .reset_n(reset_n), .bus(if_b.slave));
  snake_engine #(.MAX_TAILS(1)) u_c (.vga_clk(vga_clk), .reset_n(reset_n), .bus(if_c.slave));
`ifdef SNAKE_TIME_LIMIT_EN
  snake_engine #(.TIME_LIMIT(10)) u_d (.vga_clk(vga_clk), .reset_n(reset_n), .bus(if_d.slave));
`else
  snake_engine u_d (.vga_clk(vga_clk), .reset_n(reset_n), .bus(if_d.slave));
`endif

  task automatic check_val(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pixel query through the scoreboard: expectation pushed with the stimulus,
  // popped when the registered entity appears one clock later.
  task automatic query_px(input int d, input int px, input int py, input int exp, input string tag);
    x_in = 10'(px);
    y_in = 10'(py);
    exp_q.push_back(2'(exp));
    @(posedge vga_clk); #1;
    check_val(tag, int'(ent[d]), int'(exp_q.pop_front()));
  endtask

  task automatic query_cell(input int d, input int cx, input int cy, input int exp, input string tag);
    query_px(d, cx * CELL + 8, cy * CELL + 8, exp, tag);
  endtask

  task automatic count_apples(input int d, output int n);
    n = 0;
    for (int cy = 0; cy < 30; cy++)
      for (int cx = 0; cx < 40; cx++) begin
        x_in = 10'(cx * CELL);
        y_in = 10'(cy * CELL);
        @(posedge vga_clk); #1;
        if (ent[d] == 2'(E_APPLE)) n++;
      end
  endtask

  task automatic tick();
    int n;
    n = 0;
    update_tick = 1'b1;
    @(posedge vga_clk); #1;
    update_tick = 1'b0;
    while ((busy[0] | busy[1] | busy[2] | busy[3]) && n < BOUND) begin
      @(posedge vga_clk); #1;
      n++;
    end
    ticks++;
    check_val("busy_fall", int'(busy[0] | busy[1] | busy[2] | busy[3]), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge vga_clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start = 1'b0; update_tick = 1'b0; direction = D_RIGHT;
    x_in = '0; y_in = '0;
    repeat (3) @(posedge vga_clk);
    #1;
    check_val("rst_entity", int'(ent[0]), E_NONE);
    check_val("rst_over",   int'(over[0]), 0);
    check_val("rst_won",    int'(won[2]), 0);
    check_val("rst_busy",   int'(busy[0]), 0);
    check_val("rst_tail",   int'(tc[0]), 0);
    reset_n = 1'b1;
    @(posedge vga_clk); #1;

    query_cell(0, 20, 15, E_HEAD,  "idle_head");
    query_cell(0, 24, 15, E_APPLE, "idle_apple");
    query_px(0, 700, 240, E_NONE, "offgrid_x");
    query_px(0, 320, 500, E_NONE, "offgrid_y");
    query_px(0, 639, 479, E_NONE, "corner_cell");

    pulse_start();
    direction = D_LEFT;
    tick();
    query_cell(0, 21, 15, E_HEAD, "reverse_reject");
    direction = D_RIGHT;
    tick();
    tick();
    query_cell(0, 23, 15, E_HEAD,  "head_23_15");
    query_px(0, 368, 240, E_HEAD,  "head_px_368_240");
    query_cell(0, 22, 15, E_NONE,  "no_body_yet");
    query_cell(0, 24, 15, E_APPLE, "apple_ahead");
    check_val("tail_before_eat", int'(tc[0]), 0);

    tick();
    check_val("a_tail_eat", int'(tc[0]), 1);
    check_val("b_tail_eat", int'(tc[1]), 1);
    query_cell(0, 24, 15, E_HEAD, "a_head_eat");
    query_cell(0, 23, 15, E_TAIL, "a_body_eat");
    count_apples(0, n);
    check_val("a_one_free_apple", n, 1);
    check_val("c_won", int'(won[2]), 1);
    check_val("c_not_over", int'(over[2]), 0);
    check_val("c_tail", int'(tc[2]), 1);

    direction = D_TOP;
    for (int j = 0; j < 15; j++) begin
      tick();
      if (ticks == 9)  check_val("d_won_t9", int'(won[3]), 0);
      if (ticks == 10) check_val("d_won_t10", int'(won[3]), TL_ON);
    end
    query_cell(0, 24, 0, E_HEAD, "a_head_top");
    check_val("a_over_pre", int'(over[0]), 0);
    tick();
    check_val("a_over", int'(over[0]), 1);
    check_val("a_over_not_won", int'(won[0]), 0);
    query_cell(0, 24, 0, E_HEAD, "a_head_held");
    query_cell(0, 24, 1, E_TAIL, "a_body_held");
    check_val("b_over", int'(over[1]), 0);
    query_cell(1, 24, 29, E_HEAD, "b_head_wrap");
    query_cell(2, 24, 15, E_HEAD, "c_head_frozen");
    check_val("c_won_sticky", int'(won[2]), 1);

    pulse_start();
    check_val("a_over_clr", int'(over[0]), 0);
    check_val("c_won_clr", int'(won[2]), 0);
    check_val("c_tail_clr", int'(tc[2]), 0);
    check_val("d_won_clr", int'(won[3]), 0);
    query_cell(2, 20, 15, E_HEAD, "c_head_restart");
    query_cell(0, 20, 15, E_HEAD, "a_head_restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
